// File: rtl/spio_sync_pkg.sv
// Shared constants and helpers for the SpiNNaker-link input synchronisers.
package spio_sync_pkg;

  // Shortest flop chain that still gives metastability protection.
  localparam int unsigned MIN_STAGES = 2;

  // Ceiling log2. Returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spio_sync_filter_bit.sv
// Single-bit synchroniser: flop chain, optional stability filter, edge pulses.
module spio_sync_filter_bit
  import spio_sync_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned FILTER  = 0,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              w_sy;
  logic              w_cur_out;
  logic              w_next_out;
  logic              r_rise;
  logic              r_fall;

  assign w_sy = r_sync[STAGES-1];

  // Synchroniser flop chain; s[0] samples the asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {STAGES{RST_VAL}};
    else     r_sync <= {r_sync[STAGES-2:0], in};
  end

  generate
    if (FILTER == 0) begin : g_bypass
      // Output is the chain tail; its next value is the stage just before it.
      assign w_cur_out  = w_sy;
      assign w_next_out = r_sync[STAGES-2];
    end else begin : g_filter
      localparam int unsigned CW = (clog2(FILTER) < 1) ? 1 : clog2(FILTER);
      localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_next_cnt;
      logic          r_out;
      logic          w_nout;

      // Count consecutive cycles of disagreement; accept on the FILTER-th.
      always_comb begin
        w_nout     = r_out;
        w_next_cnt = '0;
        if (w_sy != r_out) begin
          if (r_cnt == CNT_MAX) w_nout = w_sy;
          else                  w_next_cnt = r_cnt + 1'b1;
        end
      end

      // Filtered output level and qualification counter.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out <= RST_VAL;
          r_cnt <= '0;
        end else begin
          r_out <= w_nout;
          r_cnt <= w_next_cnt;
        end
      end

      assign w_cur_out  = r_out;
      assign w_next_out = w_nout;
    end
  endgenerate

  // Edge pulses registered on the same edge that updates the output level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= ~w_cur_out &  w_next_out;
      r_fall <=  w_cur_out & ~w_next_out;
    end
  end

  assign out  = w_cur_out;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/spio_spinnaker_link_filtered_sync.sv
// Multi-bit synchroniser for SpiNNaker-link control pins; one filter per bit.
module spio_spinnaker_link_filtered_sync
  import spio_sync_pkg::*;
#(
  parameter int unsigned SIZE    = 1,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned FILTER  = 0,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in,
  output logic [SIZE-1:0] out,
  output logic [SIZE-1:0] rise,
  output logic [SIZE-1:0] fall,
  output logic            changed
);

  generate
    if (STAGES < MIN_STAGES || SIZE < 1) begin : g_bad_params
      $fatal(1, "spio_spinnaker_link_filtered_sync: STAGES must be >= 2 and SIZE >= 1");
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
      spio_sync_filter_bit #(
        .STAGES  (STAGES),
        .FILTER  (FILTER),
        .RST_VAL (RST_VAL)
      ) u_bit (
        .clk  (clk),
        .rst  (rst),
        .in   (in[gi]),
        .out  (out[gi]),
        .rise (rise[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_spio_spinnaker_link_filtered_sync.sv
// Self-checking bench: directed reset/latency/glitch tests plus a random run
// against a scoreboard fed by a behavioural reference model.
module tb_spio_spinnaker_link_filtered_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // DUT A: SIZE=4, STAGES=3, FILTER=0, RST_VAL=1
  logic       rst_a;
  logic [3:0] in_a, out_a, rise_a, fall_a;
  logic       chg_a;
  spio_spinnaker_link_filtered_sync #(.SIZE(4), .STAGES(3), .FILTER(0), .RST_VAL(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));

  // DUT B: SIZE=1, STAGES=2, FILTER=4, RST_VAL=0
  logic rst_b;
  logic in_b, out_b, rise_b, fall_b, chg_b;
  spio_spinnaker_link_filtered_sync #(.SIZE(1), .STAGES(2), .FILTER(4), .RST_VAL(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));

  // DUT C: SIZE=3, STAGES=2, FILTER=3, RST_VAL=0 (random vs model)
  logic       rst_c;
  logic [2:0] in_c, out_c, rise_c, fall_c;
  logic       chg_c;
  spio_spinnaker_link_filtered_sync #(.SIZE(3), .STAGES(2), .FILTER(3), .RST_VAL(1'b0)) u_c (
    .clk(clk), .rst(rst_c), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c), .changed(chg_c));

  typedef struct packed {
    logic [2:0] o;
    logic [2:0] r;
    logic [2:0] f;
    logic       c;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state for DUT C
  logic [2:0] m_s0, m_s1, m_out;
  int         m_cnt [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One model step for DUT C: in_v is what the next edge samples.
  task automatic model_step(input logic [2:0] in_v);
    logic [2:0] nout;
    exp_t       e;
    nout = m_out;
    for (int i = 0; i < 3; i++) begin
      if (m_s1[i] == m_out[i])  m_cnt[i] = 0;
      else if (m_cnt[i] < 2)    m_cnt[i] = m_cnt[i] + 1;
      else begin
        nout[i]  = m_s1[i];
        m_cnt[i] = 0;
      end
    end
    e.o = nout;
    e.r = ~m_out & nout;
    e.f = m_out & ~nout;
    e.c = |(e.r | e.f);
    sb_q.push_back(e);
    m_s1  = m_s0;
    m_s0  = in_v;
    m_out = nout;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rnd_v;
    int         hold;
    exp_t       got, exp;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    in_a = 4'h0; in_b = 1'b0; in_c = 3'h0;
    #2;
    // Reset state with in=0 and RST_VAL=1
    chk("rst_out_a",  out_a,  4'hF);
    chk("rst_rise_a", rise_a, 4'h0);
    chk("rst_fall_a", fall_a, 4'h0);
    chk("rst_chg_a",  chg_a,  1'b0);
    chk("rst_out_b",  out_b,  1'b0);
    chk("rst_out_c",  out_c,  3'h0);
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // DUT A leaves reset value: in=0 reaches out after 3 edges
    tick(); tick();
    chk("a_hold_rstval", out_a, 4'hF);
    tick();
    chk("a_out_to0",  out_a, 4'h0);
    chk("a_fall_all", fall_a, 4'hF);
    chk("a_chg_fall", chg_a, 1'b1);
    tick();
    chk("a_fall_clr", fall_a, 4'h0);
    chk("a_chg_clr",  chg_a, 1'b0);

    // FILTER=0, STAGES=3 latency and single-cycle rise
    in_a = 4'h1;
    tick();
    chk("a_lat_e1", out_a, 4'h0);
    tick();
    chk("a_lat_e2", out_a, 4'h0);
    chk("a_lat_e2_rise", rise_a, 4'h0);
    tick();
    chk("a_lat_e3", out_a, 4'h1);
    chk("a_rise_e3", rise_a, 4'h1);
    tick();
    chk("a_rise_e4", rise_a, 4'h0);
    chk("a_out_e4", out_a, 4'h1);

    // Simultaneous multi-bit change
    in_a = 4'b0101;
    repeat (4) tick();
    chk("a_pre_0101", out_a, 4'b0101);
    in_a = 4'b1010;
    tick(); tick();
    chk("a_multi_e2_chg", chg_a, 1'b0);
    tick();
    chk("a_multi_rise", rise_a, 4'b1010);
    chk("a_multi_fall", fall_a, 4'b0101);
    chk("a_multi_chg",  chg_a, 1'b1);
    tick();
    chk("a_multi_rise_clr", rise_a, 4'h0);
    chk("a_multi_fall_clr", fall_a, 4'h0);
    chk("a_multi_chg_clr",  chg_a, 1'b0);
    chk("a_multi_out", out_a, 4'b1010);

    // Asynchronous reset between edges
    #1;
    rst_a = 1'b1;
    #1;
    chk("a_async_out",  out_a, 4'hF);
    chk("a_async_rise", rise_a, 4'h0);
    chk("a_async_fall", fall_a, 4'h0);
    tick();
    rst_a = 1'b0;

    // FILTER=4, STAGES=2: clean step needs 6 edges
    in_b = 1'b1;
    repeat (5) tick();
    chk("b_step_e5", out_b, 1'b0);
    tick();
    chk("b_step_e6", out_b, 1'b1);
    chk("b_rise_e6", rise_b, 1'b1);
    tick();
    chk("b_rise_e7", rise_b, 1'b0);
    in_b = 1'b0;
    repeat (5) tick();
    chk("b_fstep_e5", out_b, 1'b1);
    tick();
    chk("b_fstep_e6", out_b, 1'b0);
    chk("b_fall_e6", fall_b, 1'b1);
    tick();
    chk("b_fall_e7", fall_b, 1'b0);

    // Short glitches (3 high, 1 low, repeated) never qualify
    for (int g = 0; g < 3; g++) begin
      in_b = 1'b1;
      repeat (3) tick();
      in_b = 1'b0;
      tick();
      chk("b_glitch_out", out_b, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b_glitch_quiet", {out_b, rise_b, fall_b}, 3'b000);
    end

    // Reset with count at 3 forces a fresh full qualification
    in_b = 1'b1;
    repeat (5) tick();
    chk("b_pend_e5", out_b, 1'b0);
    #1;
    rst_b = 1'b1;
    #1;
    chk("b_rst_out",  out_b, 1'b0);
    chk("b_rst_rise", rise_b, 1'b0);
    tick();
    rst_b = 1'b0;
    repeat (5) tick();
    chk("b_requal_e5", out_b, 1'b0);
    chk("b_requal_e5_rise", rise_b, 1'b0);
    tick();
    chk("b_requal_e6", out_b, 1'b1);
    chk("b_requal_rise", rise_b, 1'b1);

    // Random stimulus on DUT C against the reference model
    m_s0 = '0; m_s1 = '0; m_out = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    hold  = 0;
    rnd_v = '0;
    for (int k = 0; k < 10000; k++) begin
      if (hold == 0) begin
        rnd_v = 3'($urandom);
        hold  = $urandom_range(1, 6);
      end
      hold = hold - 1;
      in_c = rnd_v;
      model_step(rnd_v);
      tick();
      got = '{o: out_c, r: rise_c, f: fall_c, c: chg_c};
      if (sb_q.size() == 0) begin
        chk("c_sb_empty", 32'd0, 32'd1);
      end else begin
        exp = sb_q.pop_front();
        chk("c_random", 32'(got), 32'(exp));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
